// File: rtl/spiflash_wb_reader_pkg.sv
// Shared types and constants for the Wishbone-to-SPI-flash read bridge.
package spiflash_wb_reader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_ACK,
      S_HOLD,
      S_CSWAIT,
      S_ERR
   } state_t;

   localparam logic [7:0] SPI_CMD_READ = 8'h03;
   localparam logic [5:0] CMD_BITS     = 6'd8;
   localparam logic [5:0] ADDR_BITS    = 6'd24;
   localparam logic [5:0] DATA_BITS    = 6'd32;

   // Flash streams bytes MSB-first; the first byte received lands in the low lane.
   function automatic logic [31:0] flash_to_wb(input logic [31:0] rx);
      return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
   endfunction

endpackage

// File: rtl/spiflash_shift_engine.sv
// SPI mode-0 bit engine: SCK prescaler plus 32-bit MSB-first TX/RX shifter.
module spiflash_shift_engine #(
   parameter int CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [5:0]  nbits,
   input  logic [31:0] tx_word,
   input  logic        miso,
   output logic        done,
   output logic [31:0] rx_word,
   output logic        sck,
   output logic        mosi
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic          active;
   logic [DW-1:0] div;
   logic [5:0]    left;
   logic [31:0]   tx_sh;
   logic          tick;

   assign tick = active && (div == DW'(CLK_DIV - 1));
   // done is combinational so a chained start lands on the final falling edge, no gap bit.
   assign done = tick && sck && (left == 6'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 1'b0;
         div     <= '0;
         left    <= '0;
         tx_sh   <= '0;
         rx_word <= '0;
         sck     <= 1'b0;
         mosi    <= 1'b0;
      end else if (abort) begin
         active <= 1'b0;
         div    <= '0;
         left   <= '0;
         sck    <= 1'b0;
         mosi   <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         div    <= '0;
         left   <= nbits;
         sck    <= 1'b0;
         mosi   <= tx_word[31];
         tx_sh  <= {tx_word[30:0], 1'b0};
      end else if (active) begin
         if (tick) begin
            div <= '0;
            sck <= ~sck;
            if (!sck) begin
               rx_word <= {rx_word[30:0], miso};
            end else begin
               left  <= left - 6'd1;
               mosi  <= tx_sh[31];
               tx_sh <= {tx_sh[30:0], 1'b0};
               if (left == 6'd1)
                  active <= 1'b0;
            end
         end else begin
            div <= div + DW'(1);
         end
      end
   end

endmodule

// File: rtl/spiflash_wb_reader.sv
// Read-only Wishbone slave serving the flash window via SPI READ (0x03),
// holding CS low after each word so sequential reads stream without re-addressing.
module spiflash_wb_reader
   import spiflash_wb_reader_pkg::*;
#(
   parameter int CLK_DIV      = 1,
   parameter int IDLE_TIMEOUT = 16,
   parameter int CS_HIGH_MIN  = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [21:0] wb_adr_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        spiflash_cs_n,
   output logic        spiflash_clk,
   output logic        spiflash_mosi,
   input  logic        spiflash_miso,
   output logic        busy
);

   localparam int HW = $clog2(IDLE_TIMEOUT + 1);
   localparam int CW = $clog2(CS_HIGH_MIN + 1);

   state_t        state;
   logic [21:0]   adr_q;
   logic          launch;
   logic          pending;
   logic [HW-1:0] hold_cnt;
   logic [CW-1:0] cw_cnt;

   logic          eng_start;
   logic [5:0]    eng_nbits;
   logic [31:0]   eng_tx;
   logic          eng_done;
   logic [31:0]   eng_rx;

   logic          rd_req;
   logic          wr_req;
   logic          seq_hit;
   logic          xfer_abort;
   logic          sel_unused;

   assign sel_unused = ^wb_sel_i;
   assign rd_req     = wb_cyc_i && wb_stb_i && !wb_we_i;
   assign wr_req     = wb_cyc_i && wb_stb_i && wb_we_i;
   assign seq_hit    = (wb_adr_i == adr_q + 22'd1);
   assign xfer_abort = !wb_cyc_i && (state == S_CMD || state == S_ADDR || state == S_DATA);
   assign busy       = (state != S_IDLE);

   // CMD -> ADDR -> DATA are chained off eng_done so the bit stream is continuous.
   always_comb begin
      eng_start = 1'b0;
      eng_nbits = DATA_BITS;
      eng_tx    = '0;
      case (state)
         S_CMD: begin
            if (launch) begin
               eng_start = 1'b1;
               eng_nbits = CMD_BITS;
               eng_tx    = {SPI_CMD_READ, 24'h0};
            end else if (eng_done) begin
               eng_start = 1'b1;
               eng_nbits = ADDR_BITS;
               eng_tx    = {adr_q, 2'b00, 8'h00};
            end
         end
         S_ADDR:  eng_start = eng_done;
         S_DATA:  eng_start = launch;
         default: eng_start = 1'b0;
      endcase
   end

   spiflash_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .start   (eng_start),
      .abort   (xfer_abort),
      .nbits   (eng_nbits),
      .tx_word (eng_tx),
      .miso    (spiflash_miso),
      .done    (eng_done),
      .rx_word (eng_rx),
      .sck     (spiflash_clk),
      .mosi    (spiflash_mosi)
   );

   // The request is ignored while ack/err is high: the master still holds stb that cycle.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= S_IDLE;
         spiflash_cs_n <= 1'b1;
         wb_ack_o      <= 1'b0;
         wb_err_o      <= 1'b0;
         wb_dat_o      <= '0;
         adr_q         <= '0;
         launch        <= 1'b0;
         pending       <= 1'b0;
         hold_cnt      <= '0;
         cw_cnt        <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         launch   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!wb_err_o && wr_req) begin
                  state <= S_ERR;
               end else if (!wb_err_o && rd_req) begin
                  adr_q         <= wb_adr_i;
                  spiflash_cs_n <= 1'b0;
                  launch        <= 1'b1;
                  state         <= S_CMD;
               end
            end
            S_ERR: begin
               wb_err_o <= 1'b1;
               state    <= S_IDLE;
            end
            S_CMD, S_ADDR, S_DATA: begin
               if (xfer_abort) begin
                  spiflash_cs_n <= 1'b1;
                  pending       <= 1'b0;
                  cw_cnt        <= '0;
                  state         <= S_CSWAIT;
               end else if (eng_done) begin
                  case (state)
                     S_CMD:  state <= S_ADDR;
                     S_ADDR: state <= S_DATA;
                     default: begin
                        wb_dat_o <= flash_to_wb(eng_rx);
                        state    <= S_ACK;
                     end
                  endcase
               end
            end
            S_ACK: begin
               wb_ack_o <= 1'b1;
               hold_cnt <= '0;
               state    <= S_HOLD;
            end
            S_HOLD: begin
               if (!wb_ack_o && !wb_err_o && rd_req) begin
                  adr_q    <= wb_adr_i;
                  hold_cnt <= '0;
                  if (seq_hit) begin
                     launch <= 1'b1;
                     state  <= S_DATA;
                  end else begin
                     spiflash_cs_n <= 1'b1;
                     pending       <= 1'b1;
                     cw_cnt        <= '0;
                     state         <= S_CSWAIT;
                  end
               end else begin
                  if (!wb_ack_o && !wb_err_o && wr_req)
                     wb_err_o <= 1'b1;
                  if (hold_cnt == HW'(IDLE_TIMEOUT - 1)) begin
                     spiflash_cs_n <= 1'b1;
                     pending       <= 1'b0;
                     cw_cnt        <= '0;
                     state         <= S_CSWAIT;
                  end else begin
                     hold_cnt <= hold_cnt + HW'(1);
                  end
               end
            end
            S_CSWAIT: begin
               if (cw_cnt == CW'(CS_HIGH_MIN - 1)) begin
                  pending <= 1'b0;
                  if (pending && rd_req) begin
                     spiflash_cs_n <= 1'b0;
                     launch        <= 1'b1;
                     state         <= S_CMD;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cw_cnt <= cw_cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
